// File: rtl/seg_pkg.sv
// Shared definitions for the segment display scan path.
package seg_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam logic [3:0]  BCD_BLANK  = 4'hF;
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned MAX_IDX_W  = 3;

  // One-hot select for a digit index; callers cast down to their digit count.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler: tick is high for one cycle every DIV clocks.
module scan_tick_gen #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    tick    = (count_q == CNT_W'(DIV - 1));
    count_d = tick ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed BCD digit scanner with frame-boundary commit of new values.
// Optional SEG_BLINK_EN adds a blink input that blanks every 16 of 32 frames.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned LZ_BLANK    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
`ifdef SEG_BLINK_EN
  input  logic                        blink,
`endif
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] value_bcd,
  output logic                        ready,
  output logic [BCD_W-1:0]            bch,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        frame_done
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned VAL_W = BCD_W * NUM_DIGITS;

  logic                  tick;
  logic                  last_c;
  logic                  frame_end_c;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      disp_q, disp_d;
  logic [VAL_W-1:0]      pend_val_q, pend_val_d;
  logic                  pend_q, pend_d;
  logic [BCD_W-1:0]      bch_q, bch_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;

  logic [NUM_DIGITS-1:0] lz_c;
  logic                  zero_run_c;
  logic [BCD_W-1:0]      sel_c;
  logic                  sel_blank_c;
  logic                  blank_all_c;

  scan_tick_gen #(
    .DIV (REFRESH_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Scan index, handshake capture and frame-boundary commit.
  always_comb begin
    idx_d       = idx_q;
    disp_d      = disp_q;
    pend_val_d  = pend_val_q;
    pend_d      = pend_q;
    last_c      = (idx_q == IDX_W'(NUM_DIGITS - 1));
    frame_end_c = tick && last_c;

    if (tick) begin
      idx_d = last_c ? '0 : idx_q + IDX_W'(1);
    end

    if (frame_end_c && pend_q) begin
      disp_d = pend_val_q;
      pend_d = 1'b0;
    end else if (load && !pend_q) begin
      pend_val_d = value_bcd;
      pend_d     = 1'b1;
    end
  end

`ifdef SEG_BLINK_EN
  logic [4:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_end_c ? frame_cnt_q + 5'd1 : frame_cnt_q;
    blank_all_c = blink && frame_cnt_d[4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  always_comb begin
    blank_all_c = 1'b0;
  end
`endif

  // Output stage looks at next-state values so it lines up with the index change.
  always_comb begin
    lz_c        = '0;
    zero_run_c  = 1'b1;
    sel_c       = '0;
    sel_blank_c = 1'b0;

    for (int k = 0; k < NUM_DIGITS; k++) begin
      int unsigned kk;
      kk         = NUM_DIGITS - 1 - k;
      zero_run_c = zero_run_c && (disp_d[kk*BCD_W +: BCD_W] == '0);
      lz_c[kk]   = (LZ_BLANK != 0) && zero_run_c && (kk != 0);
    end

    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        sel_c       = disp_d[k*BCD_W +: BCD_W];
        sel_blank_c = lz_c[k];
      end
    end

    bch_d      = (sel_blank_c || blank_all_c) ? BCD_BLANK : sel_c;
    digit_en_d = NUM_DIGITS'(onehot(MAX_IDX_W'(idx_d)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      disp_q     <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      bch_q      <= '0;
      digit_en_q <= NUM_DIGITS'(1);
    end else begin
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      bch_q      <= bch_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign bch        = bch_q;
  assign digit_en   = digit_en_q;
  assign ready      = !pend_q;
  assign frame_done = frame_end_c;

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
Time-multiplexes one shared BCD-to-7-segment decoder across NUM_DIGITS common-cathode digits. Holds a committed display value and walks the digits at a fixed refresh rate, driving the BCD code and a one-hot digit enable. New values arrive through a valid/ready handshake and commit only at frame boundaries, so a frame never shows a mix of old and new digits. Sits between the game/score logic and the decoder and digit-select pins.

Parameters:
NUM_DIGITS, 4, digits scanned per frame (2..8)
REFRESH_DIV, 50000, clk cycles each digit is held (dwell); must be >= 2
LZ_BLANK, 1, 1 = blank leading zeros (digit 0 is never blanked)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  new-value valid strobe
value_bcd  in  4*NUM_DIGITS  packed BCD; digit 0 = bits [3:0] (least significant)
ready  out  1  high when a load is accepted this cycle
bch  out  4  BCD code to the shared decoder; 4'hF = blank (decoder default output is all-off)
digit_en  out  NUM_DIGITS  one-hot active-high digit select
frame_done  out  1  one-cycle pulse on the tick that ends the last digit's dwell

Behaviour:
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick = (count == REFRESH_DIV-1).
- Digit index idx: advances on tick, wrapping NUM_DIGITS-1 -> 0.
- bch and digit_en are registered. Both update on the same edge as the idx change, so there is one cycle of latency from tick. digit_en is always exactly one-hot and never all-zero after reset.
- Registers:
  - disp_reg: committed value.
  - pend_reg: captured value.
  - pend: flag, set when pend_reg holds an uncommitted value.
- Handshake:
  - ready = !pend.
  - load && ready: capture value_bcd into pend_reg and set pend.
  - load while !ready: ignored; no capture, no error.
- Commit: on a tick with idx == NUM_DIGITS-1 and pend set:
  - disp_reg <= pend_reg and pend clears.
  - The first digit-0 slot of the new frame shows the new value.
  - ready returns high the cycle after commit.
- Simultaneous commit and load: a load in the commit cycle sees ready=0 and is dropped.
- frame_done pulses on every frame-end tick, whether or not a commit happens.
- Leading-zero blanking (LZ_BLANK=1):
  - Digit k is blanked (bch=4'hF) if digits NUM_DIGITS-1 down to k of disp_reg are all zero and k != 0.
  - Blanking is evaluated from disp_reg at output-register time.
- Non-BCD nibbles (A..F) pass through unchanged; the decoder blanks them. They count as non-zero for blanking.
- Reset (any cycle, including mid-frame or with a pending load):
  - count=0, idx=0, disp_reg=0, pend_reg=0, pend=0.
  - digit_en = one-hot digit 0, bch = 4'h0 (shows "0"), frame_done=0, ready=1 from the first post-reset cycle.
  - A pending uncommitted value is discarded.

Optional Feature:
SEG_BLINK_EN
- Defined:
  - Adds input port blink (1 bit) and a 5-bit frame counter, incremented on frame_done and cleared on reset.
  - While blink=1 and frame_counter[4]=1, bch is forced to 4'hF for all digits.
  - Scan, digit_en and the handshake are unaffected.
- Undefined: the port and counter are absent; behaviour as above.

Decomposition:
- Shared package seg_pkg:
  - BCD_W=4.
  - BCD_BLANK=4'hF.
  - Function for one-hot from index.
- Sub-module scan_tick_gen (prescaler):
  - Parameter DIV, ports clk/reset/tick.
  - Reused later for debounce and blink timing.
- The decoder stays outside this block; it is instantiated once at top level on bch.

Test Plan:
(All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, LZ_BLANK=1.)
1. Reset release, no load -> digit_en cycles 0001,0010,0100,1000 every 4 clk. bch = 0,F,F,F. frame_done pulses once per 16 clk.
2. load with value 16'h1234 while ready=1 -> ready low next cycle. Frame in progress keeps showing old value. After frame_done, the next frame shows bch 4,3,2,1 and ready=1.
3. value 16'h0050 -> bch 0,5,F,F (digit 3 blanked, digit 2 blanked, zeros below 5 shown). Value 16'h0000 -> 0,F,F,F.
4. Second load (16'h9999) while pend=1, then load asserted on the commit cycle -> both ignored. Display commits the first value only. ready rises the cycle after commit.
5. Assert reset mid-frame (idx=2) with pend=1 -> next cycle: digit_en=0001, bch=0, ready=1. The pending value never appears.
6. SEG_BLINK_EN defined, blink=1, value 16'h0042 -> frames 0-15 show 2,4,F,F. Frames 16-31 show bch=F on all digits while digit_en still scans.
